trace_frame_rx: RTL

- Host-side collector for one acquisition frame from the sensor/AES target board over UART.
- Sends a 1-byte command, which is the sensor delay setting; this command triggers the target's encryption run.
- Then receives the target's fixed frame: 16 plaintext bytes, 16 key bytes, 16 ciphertext bytes, then SAMPLES sensor bytes. All are stored in local buffers, which a downstream reader or logic analyser drains through a registered read port.
- Sits between a uart_tx/uart_rx pair on the collector board and the trace-processing logic.

---
 rtl/trace_frame_rx_if.sv | 12 +
 rtl/trace_frame_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/trace_frame_rx_if.sv
// UART-side link between the frame collector and its uart_tx/uart_rx pair.
// master = collector (drives the send strobe/byte), slave = UART pair.
interface trace_frame_rx_if;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       rx_dv;
  logic [7:0] rx_byte;

  modport master (output tx_dv, tx_byte, input tx_done, rx_dv, rx_byte);
  modport slave  (input tx_dv, tx_byte, output tx_done, rx_dv, rx_byte);
endinterface

// File: rtl/trace_frame_rx.sv
// Host-side acquisition of one AES/sensor frame: sends the delay command, then
// stores PT/KEY/CT (16 bytes each) and SAMPLES sensor bytes behind a registered read port.
module trace_frame_rx #(
  parameter int SAMPLES    = 1024,
  parameter int ADDR_W     = 10,
  parameter int MARKER_VAL = 255,
  parameter int TIMEOUT    = 2000000
) (
  input  logic              clk,
  input  logic              c10_resetn,
  trace_frame_rx_if.master  uart,
  input  logic              start,
  input  logic [7:0]        delay_cfg,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic              marker_found,
  output logic [ADDR_W-1:0] marker_idx,
  input  logic [1:0]        rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(SAMPLES - 1);
  localparam logic [7:0]        MARKER_B  = 8'(MARKER_VAL);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CMD_SEND = 4'd1;
  localparam logic [3:0] S_CMD_WAIT = 4'd2;
  localparam logic [3:0] S_RX_PT    = 4'd3;
  localparam logic [3:0] S_RX_KEY   = 4'd4;
  localparam logic [3:0] S_RX_CT    = 4'd5;
  localparam logic [3:0] S_RX_SMP   = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mk_found_q, mk_found_d;
  logic [ADDR_W-1:0] mk_idx_q, mk_idx_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic [2:0]        hdr_we;
  logic              smp_we;
  logic [7:0]        hdr_rd [3];
  logic [7:0]        smp_mem [SAMPLES];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    to_cnt_d   = to_cnt_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mk_found_d = mk_found_q;
    mk_idx_d   = mk_idx_q;
    hdr_we     = 3'b000;
    smp_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_byte_d  = delay_cfg;
          mk_found_d = 1'b0;
          mk_idx_d   = '0;
          busy_d     = 1'b1;
          tx_dv_d    = 1'b1;
          state_d    = S_CMD_SEND;
        end
      end
      S_CMD_SEND: state_d = S_CMD_WAIT;
      S_CMD_WAIT: begin
        if (uart.tx_done) begin
          idx_d    = '0;
          to_cnt_d = '0;
          state_d  = S_RX_PT;
        end
      end
      S_RX_PT, S_RX_KEY, S_RX_CT, S_RX_SMP: begin
        // A byte landing on the expiry cycle wins over the timeout.
        if (uart.rx_dv) begin
          to_cnt_d = '0;
          if (state_q == S_RX_SMP) begin
            smp_we = 1'b1;
            if (uart.rx_byte == MARKER_B && !mk_found_q) begin
              mk_found_d = 1'b1;
              mk_idx_d   = idx_q;
            end
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            hdr_we = {state_q == S_RX_CT, state_q == S_RX_KEY, state_q == S_RX_PT};
            if (idx_q[3:0] == 4'hF) begin
              idx_d   = '0;
              state_d = (state_q == S_RX_PT)  ? S_RX_KEY :
                        (state_q == S_RX_KEY) ? S_RX_CT  : S_RX_SMP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d = '0;
          idx_d    = '0;
          err_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (rd_sel)
      2'd0:    rd_data_d = hdr_rd[0];
      2'd1:    rd_data_d = hdr_rd[1];
      2'd2:    rd_data_d = hdr_rd[2];
      default: rd_data_d = smp_mem[rd_addr];
    endcase
  end

  always_ff @(posedge clk or negedge c10_resetn) begin
    if (!c10_resetn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mk_found_q <= 1'b0;
      mk_idx_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mk_found_q <= mk_found_d;
      mk_idx_q   <= mk_idx_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Header buffers: one 16-byte array each for PT, KEY and CT.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hdr
      logic [7:0] mem [16];
      always_ff @(posedge clk) begin
        if (hdr_we[gi]) mem[idx_q[3:0]] <= uart.rx_byte;
      end
      assign hdr_rd[gi] = mem[rd_addr[3:0]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (smp_we) smp_mem[idx_q] <= uart.rx_byte;
  end

  assign uart.tx_dv    = tx_dv_q;
  assign uart.tx_byte  = tx_byte_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;
  assign marker_found  = mk_found_q;
  assign marker_idx    = mk_idx_q;
  assign rd_data       = rd_data_q;
endmodule
